// File: rtl/rca_wide_add_seq.sv
// Multi-word add/subtract engine: one shared 32-bit ripple-carry adder walks
// WORDS words LSW first, carrying between words through a register.

module fulladder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[32];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one word per cycle through the shared adder
// DONE  | result presented, waiting for out_ready
module rca_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [WORDS*32-1:0]   in_a,
  input  logic [WORDS*32-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*32-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);
  localparam int W  = WORDS * 32;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [31:0]    a_word, b_word, sum_word;
  logic           cout_word;
  logic           last_word;
  logic           accept;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IW'(w)) begin
        a_word = a_q[w*32 +: 32];
        b_word = b_q[w*32 +: 32];
      end
    end
  end

  fulladder_32bit u_add (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .sum  (sum_word),
    .cout (cout_word)
  );

  assign last_word = (idx_q == IW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      // subtraction is a + ~b + 1: invert b here, seed the carry with 1
      a_q     <= in_a;
      b_q     <= in_b ^ {W{in_sub}};
      carry_q <= in_sub;
      idx_q   <= '0;
      out_sum <= '0;
    end else if (state == RUN) begin
      for (int w = 0; w < WORDS; w++) begin
        if (idx_q == IW'(w)) out_sum[w*32 +: 32] <= sum_word;
      end
      carry_q <= cout_word;
      if (last_word) begin
        out_cout <= cout_word;
        out_ovf  <= (a_q[W-1] == b_q[W-1]) && (sum_word[31] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rca_wide_add_seq.sv
// Directed bench for rca_wide_add_seq: a WORDS=4 and a WORDS=1 instance
// driven in sequence, checked with immediate assertions.

module tb_rca_wide_add_seq;
  logic         clk = 1'b0;
  logic         rst;

  logic         in_valid, in_sub, out_ready;
  logic [127:0] in_a, in_b;
  logic         in_ready, out_valid, out_cout, out_ovf;
  logic [127:0] out_sum;

  logic         in_valid1, in_sub1, out_ready1;
  logic [31:0]  in_a1, in_b1;
  logic         in_ready1, out_valid1, out_cout1, out_ovf1;
  logic [31:0]  out_sum1;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [127:0] held;

  always #5 clk = ~clk;

  rca_wide_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  rca_wide_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_sub(in_sub1),
    .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands at a falling edge, get accepted, then wait for out_valid.
  task automatic run4(input logic [127:0] a, input logic [127:0] b, input logic sub,
                      output int n);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    chk("in_ready_before_accept", 128'(in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release4();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handshake", 128'(in_ready), 128'd1);
    chk("out_valid_after_handshake", 128'(out_valid), 128'd0);
  endtask

  task automatic check_model(input string tag, input logic [127:0] a, input logic [127:0] b,
                             input logic sub);
    logic [127:0] be;
    logic [128:0] full;
    logic         ovf;
    be   = b ^ {128{sub}};
    full = {1'b0, a} + {1'b0, be} + 129'(sub);
    ovf  = (a[127] == be[127]) && (full[127] != a[127]);
    chk({tag, "_sum"},  out_sum, full[127:0]);
    chk({tag, "_cout"}, 128'(out_cout), 128'(full[128]));
    chk({tag, "_ovf"},  128'(out_ovf), 128'(ovf));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_sub = 0; out_ready = 0; in_a = '0; in_b = '0;
    in_valid1 = 0; in_sub1 = 0; out_ready1 = 0; in_a1 = '0; in_b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",  128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_sum",   out_sum, 128'd0);
    chk("rst_out_cout",  128'(out_cout), 128'd0);
    chk("rst_out_ovf",   128'(out_ovf), 128'd0);

    // all-ones + 1: carry ripples out of the top word
    run4({128{1'b1}}, 128'd1, 1'b0, lat);
    chk("add_max_latency", 128'(lat), 128'd4);
    chk("add_max_sum",  out_sum, 128'd0);
    chk("add_max_cout", 128'(out_cout), 128'd1);
    chk("add_max_ovf",  128'(out_ovf), 128'd0);
    release4();

    run4(128'd5, 128'd7, 1'b1, lat);
    chk("sub_5_7_sum",  out_sum, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);
    chk("sub_5_7_cout", 128'(out_cout), 128'd0);
    chk("sub_5_7_ovf",  128'(out_ovf), 128'd0);
    release4();

    run4(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, lat);
    chk("add_maxpos_sum",  out_sum, 128'h80000000_00000000_00000000_00000000);
    chk("add_maxpos_cout", 128'(out_cout), 128'd0);
    chk("add_maxpos_ovf",  128'(out_ovf), 128'd1);
    release4();

    run4(128'h01234567_89ABCDEF_FEDCBA98_76543210,
         128'hF0F0F0F0_0F0F0F0F_80000000_FFFFFFFF, 1'b0, lat);
    check_model("add_mix", 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                128'hF0F0F0F0_0F0F0F0F_80000000_FFFFFFFF, 1'b0);
    release4();

    run4(128'h80000000_00000000_00000000_00000000, 128'd1, 1'b1, lat);
    check_model("sub_minneg", 128'h80000000_00000000_00000000_00000000, 128'd1, 1'b1);

    // stall in DONE while a new request is offered
    held = out_sum;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_a = 128'd11; in_b = 128'd22; in_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i == 3 || i == 9) begin
        chk("hold_out_valid", 128'(out_valid), 128'd1);
        chk("hold_in_ready",  128'(in_ready), 128'd0);
        chk("hold_out_sum",   out_sum, held);
        chk("hold_out_ovf",   128'(out_ovf), 128'd1);
      end
    end
    in_valid = 1'b0;
    release4();
    chk("idle_keeps_sum", out_sum, held);

    run4(128'd100, 128'd23, 1'b0, lat);
    chk("after_hold_sum", out_sum, 128'd123);
    release4();

    // reset mid-operation (idx=2)
    @(negedge clk);
    in_a = {4{32'hFFFFFFFF}}; in_b = 128'd1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_sum",   out_sum, 128'd0);

    run4(128'd3, 128'd4, 1'b0, lat);
    chk("abort_next_latency", 128'(lat), 128'd4);
    chk("abort_next_sum",  out_sum, 128'd7);
    chk("abort_next_cout", 128'(out_cout), 128'd0);
    release4();

    // single-word build
    @(negedge clk);
    in_a1 = 32'hFFFFFFFF; in_b1 = 32'd1; in_sub1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("w1_add_latency", 128'(lat), 128'd1);
    chk("w1_add_sum",  128'(out_sum1), 128'd0);
    chk("w1_add_cout", 128'(out_cout1), 128'd1);
    chk("w1_add_ovf",  128'(out_ovf1), 128'd0);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("w1_in_ready", 128'(in_ready1), 128'd1);

    in_a1 = 32'h80000000; in_b1 = 32'd1; in_sub1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("w1_sub_valid", 128'(out_valid1), 128'd1);
    chk("w1_sub_sum",  128'(out_sum1), 128'h7FFFFFFF);
    chk("w1_sub_cout", 128'(out_cout1), 128'd1);
    chk("w1_sub_ovf",  128'(out_ovf1), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
